// File: rtl/ternary_pkg.sv
// Shared ternary types for the branch resolver slice.
//   trit_t      : balanced trit encoding (T_ZERO / T_POS / T_NEG)
//   brq_entry_t : default branch-queue entry {pred, alt_pc}
//   brr_state_t : resolver control state
package ternary_pkg;

  typedef enum logic [1:0] {
    T_ZERO = 2'b00,
    T_POS  = 2'b01,
    T_NEG  = 2'b10
  } trit_t;

  localparam int BR_PC_TRITS = 8;

  typedef struct packed {
    logic                    pred;
    trit_t [BR_PC_TRITS-1:0] alt_pc;
  } brq_entry_t;

  typedef enum logic {
    BRR_RUN   = 1'b0,
    BRR_FLUSH = 1'b1
  } brr_state_t;

endpackage

// File: rtl/ternary_brq_fifo.sv
// In-order branch queue.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_push, i_data : write an entry at the tail (ignored when full)
//   i_pop          : retire the head (ignored when empty)
//   i_clear        : drop every entry; wins over push and pop
//   o_head         : oldest entry
//   o_full, o_empty, o_count : occupancy
module ternary_brq_fifo
  import ternary_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = brq_entry_t,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  T              i_data,
  input  logic          i_pop,
  input  logic          i_clear,
  output T              o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !i_clear && !o_full;
  assign w_do_pop  = i_pop  && !i_clear && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
    end
  end

  // Storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/ternary_branch_resolver.sv
// Tracks predicted branches from decode to execute, detects mispredicts,
// issues a one-cycle flush with redirect PC, holds decode for a refill
// window and keeps saturating accuracy counters.
//   dec_*          : branch push from decode, dec_ready back-pressure
//   ex_valid/taken : resolution of the oldest outstanding branch
//   flush_o, redirect_pc_o : flush pulse and fetch target
//   stat_*_o       : saturating resolved / mispredicted counts
//   err_o          : sticky, resolution arrived with nothing outstanding
module ternary_branch_resolver
  import ternary_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int PC_TRITS     = 8,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dec_valid,
  input  logic                 dec_is_branch,
  input  logic                 dec_predict_taken,
  input  trit_t [PC_TRITS-1:0] dec_alt_pc,
  output logic                 dec_ready,
  input  logic                 ex_valid,
  input  logic                 ex_taken,
  output logic                 flush_o,
  output trit_t [PC_TRITS-1:0] redirect_pc_o,
  output logic [CNT_W-1:0]     stat_branches_o,
  output logic [CNT_W-1:0]     stat_mispredicts_o,
  output logic                 err_o
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int FCW = $clog2(FLUSH_CYCLES + 1);

  typedef struct packed {
    logic                 pred;
    trit_t [PC_TRITS-1:0] alt_pc;
  } entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  brr_state_t     r_state, w_state_nxt;
  logic [FCW-1:0] r_fcnt, w_fcnt_nxt;
  entry_t         w_push_entry;
  entry_t         w_head;
  logic           w_full;
  logic           w_empty;
  logic [CW-1:0]  w_count;
  logic           w_push;
  logic           w_resolve;
  logic           w_mispredict;
  logic           w_err_ev;

  assign w_push_entry = '{pred: dec_predict_taken, alt_pc: dec_alt_pc};

  // Ready depends only on registered state, never on ex_*.
  assign dec_ready    = (r_state == BRR_RUN) && !w_full;
  assign w_push       = dec_valid && dec_is_branch && dec_ready;
  assign w_resolve    = (r_state == BRR_RUN) && ex_valid && (w_count != '0);
  assign w_mispredict = w_resolve && (ex_taken != w_head.pred);
  assign w_err_ev     = (r_state == BRR_RUN) && ex_valid && w_empty;

  // A mispredict clears the queue, which also discards a same-cycle push.
  ternary_brq_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_resolve),
    .i_clear (w_mispredict),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BRR_RUN;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  // FLUSH lasts until the cycle after the counter reads zero.
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    case (r_state)
      BRR_RUN: begin
        if (w_mispredict) begin
          w_state_nxt = BRR_FLUSH;
          w_fcnt_nxt  = FCW'(FLUSH_CYCLES - 1);
        end
      end
      BRR_FLUSH: begin
        if (r_fcnt == '0) w_state_nxt = BRR_RUN;
        else              w_fcnt_nxt  = r_fcnt - FCW'(1);
      end
      default: w_state_nxt = BRR_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_o            <= 1'b0;
      redirect_pc_o      <= {PC_TRITS{T_ZERO}};
      stat_branches_o    <= '0;
      stat_mispredicts_o <= '0;
      err_o              <= 1'b0;
    end else begin
      flush_o <= w_mispredict;
      if (w_mispredict) redirect_pc_o <= w_head.alt_pc;
      if (w_resolve)    stat_branches_o <= sat_inc(stat_branches_o);
      if (w_mispredict) stat_mispredicts_o <= sat_inc(stat_mispredicts_o);
      if (w_err_ev)     err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ternary_branch_resolver.sv
module tb_ternary_branch_resolver;
  import ternary_pkg::*;

  localparam int DEPTH = 4;
  localparam int FLUSH_CYCLES = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dv = 1'b0, br = 1'b0, pt = 1'b0, exv = 1'b0, ext = 1'b0;
  trit_t [7:0] alt;
  logic ready, flush, err, ready4, flush4, err4;
  trit_t [7:0] redir, redir4;
  logic [15:0] sb, sm;
  logic [3:0]  sb4, sm4;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ternary_branch_resolver #(.DEPTH(DEPTH), .PC_TRITS(8), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dv), .dec_is_branch(br),
    .dec_predict_taken(pt), .dec_alt_pc(alt), .dec_ready(ready),
    .ex_valid(exv), .ex_taken(ext), .flush_o(flush), .redirect_pc_o(redir),
    .stat_branches_o(sb), .stat_mispredicts_o(sm), .err_o(err));

  ternary_branch_resolver #(.DEPTH(DEPTH), .PC_TRITS(8), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .dec_valid(dv), .dec_is_branch(br),
    .dec_predict_taken(pt), .dec_alt_pc(alt), .dec_ready(ready4),
    .ex_valid(exv), .ex_taken(ext), .flush_o(flush4), .redirect_pc_o(redir4),
    .stat_branches_o(sb4), .stat_mispredicts_o(sm4), .err_o(err4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic trit_t [7:0] mk_pc(input int s);
    trit_t [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = trit_t'(2'((s * 7 + i * (s + 1)) % 3));
    return p;
  endfunction

  function automatic int sat(input int n, input int w);
    return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
  endfunction

  // Behavioural model: program-order queue plus a refill hold count.
  brq_entry_t  m_q[$];
  int          m_hold, m_nb, m_nm;
  logic        m_flush, m_err;
  trit_t [7:0] m_redir;

  task automatic m_reset();
    m_q.delete();
    m_hold = 0; m_nb = 0; m_nm = 0;
    m_flush = 1'b0; m_err = 1'b0;
    m_redir = {8{T_ZERO}};
  endtask

  function automatic logic m_ready();
    return (m_hold == 0) && (m_q.size() < DEPTH);
  endfunction

  task automatic m_step();
    logic rdy, mis;
    brq_entry_t h, e;
    rdy = m_ready();
    mis = 1'b0;
    m_flush = 1'b0;
    if (m_hold > 0) begin
      m_hold--;
    end else begin
      if (exv) begin
        if (m_q.size() == 0) m_err = 1'b1;
        else begin
          h = m_q.pop_front();
          m_nb++;
          if (ext != h.pred) begin
            m_nm++;
            m_q.delete();
            m_flush = 1'b1;
            m_redir = h.alt_pc;
            m_hold  = FLUSH_CYCLES;
            mis = 1'b1;
          end
        end
      end
      if (rdy && dv && br && !mis) begin
        e.pred = pt;
        e.alt_pc = alt;
        m_q.push_back(e);
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) m_reset();
      else m_step();
      #1;
      chk("dec_ready",     32'(ready),  32'(m_ready()));
      chk("flush_o",       32'(flush),  32'(m_flush));
      chk("redirect_pc_o", 32'(redir),  32'(m_redir));
      chk("stat_branches", 32'(sb),     32'(sat(m_nb, 16)));
      chk("stat_mispred",  32'(sm),     32'(sat(m_nm, 16)));
      chk("err_o",         32'(err),    32'(m_err));
      chk("dec_ready_w4",  32'(ready4), 32'(m_ready()));
      chk("flush_o_w4",    32'(flush4), 32'(m_flush));
      chk("redirect_w4",   32'(redir4), 32'(m_redir));
      chk("err_o_w4",      32'(err4),   32'(m_err));
      chk("stat_br_w4",    32'(sb4),    32'(sat(m_nb, 4)));
      chk("stat_mis_w4",   32'(sm4),    32'(sat(m_nm, 4)));
    end
  end

  task automatic step(input logic d, input logic p, input trit_t [7:0] a,
                      input logic ev, input logic et);
    @(negedge clk);
    dv = d; br = d; pt = p; alt = a; exv = ev; ext = et;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, {8{T_ZERO}}, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  trit_t [7:0] pc_t;

  initial begin
    alt = {8{T_ZERO}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_redir", 32'(redir), 32'd0);
    chk("rst_sb",    32'(sb),    32'd0);
    chk("rst_err",   32'(err),   32'd0);

    // 1: three correctly predicted taken branches
    step(1, 1, mk_pc(1), 0, 0);
    step(1, 1, mk_pc(2), 0, 0);
    step(1, 1, mk_pc(3), 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, {8{T_ZERO}}, 1, 1);
      chk("t1_no_flush", 32'(flush), 32'd0);
    end
    chk("t1_sb", 32'(sb), 32'd3);
    chk("t1_sm", 32'(sm), 32'd0);

    // 2: mispredict on the older of two branches
    pc_t = mk_pc(5);
    step(1, 0, pc_t, 0, 0);
    step(1, 1, mk_pc(6), 0, 0);
    step(0, 0, {8{T_ZERO}}, 1, 1);
    chk("t2_flush_n1", 32'(flush), 32'd1);
    chk("t2_redir",    32'(redir), 32'(pc_t));
    chk("t2_ready_n1", 32'(ready), 32'd0);
    chk("t2_sm",       32'(sm),    32'd1);
    chk("t2_sb",       32'(sb),    32'd4);
    idle();
    chk("t2_flush_n2", 32'(flush), 32'd0);
    chk("t2_ready_n2", 32'(ready), 32'd0);
    idle();
    chk("t2_ready_n3", 32'(ready), 32'd1);

    // 3: full queue behaviour
    for (int i = 0; i < 4; i++) step(1, 1, mk_pc(10 + i), 0, 0);
    chk("t3_full_ready", 32'(ready), 32'd0);
    step(1, 0, mk_pc(20), 0, 0);
    step(1, 0, mk_pc(21), 1, 1);
    chk("t3_ready_c3", 32'(ready), 32'd1);
    step(1, 1, mk_pc(22), 1, 1);
    chk("t3_ready_pp", 32'(ready), 32'd1);
    step(1, 1, mk_pc(23), 0, 0);
    chk("t3_refull", 32'(ready), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 0, {8{T_ZERO}}, 1, 1);
    chk("t3_sb", 32'(sb), 32'd10);
    chk("t3_sm", 32'(sm), 32'd1);

    // 4: resolution with empty queue
    step(0, 0, {8{T_ZERO}}, 1, 0);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_sb",  32'(sb),  32'd10);
    chk("t4_flush", 32'(flush), 32'd0);
    step(1, 1, mk_pc(30), 0, 0);
    step(0, 0, {8{T_ZERO}}, 1, 1);
    chk("t4_err_sticky", 32'(err), 32'd1);

    // 5: twenty mispredicts saturate the narrow counters
    for (int k = 0; k < 20; k++) begin
      step(1, 0, mk_pc(100 + k), 0, 0);
      step(0, 0, {8{T_ZERO}}, 1, 1);
      idle();
      idle();
    end
    chk("t5_sb4", 32'(sb4), 32'd15);
    chk("t5_sm4", 32'(sm4), 32'd15);
    chk("t5_sb",  32'(sb),  32'd31);
    chk("t5_sm",  32'(sm),  32'd21);

    // 6: reset during flush
    step(1, 0, mk_pc(200), 0, 0);
    step(0, 0, {8{T_ZERO}}, 1, 1);
    chk("t6_in_flush", 32'(flush), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_flush", 32'(flush), 32'd0);
    chk("t6_redir", 32'(redir), 32'd0);
    chk("t6_sb",    32'(sb),    32'd0);
    chk("t6_sm",    32'(sm),    32'd0);
    chk("t6_err",   32'(err),   32'd0);
    chk("t6_ready", 32'(ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_ready_rel", 32'(ready), 32'd1);
    idle();
    chk("t6_ready_c1", 32'(ready), 32'd1);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ternary_branch_resolver.md
Name: ternary_branch_resolver

Overview:
- Tracks in-flight predicted branches between decode and execute, in program order.
- Compares each static prediction with the outcome resolved in execute. On a mispredict it issues a flush and a redirect PC.
- Holds decode during a fixed refill window after a flush.
- Keeps saturating accuracy counters for the whole core pipeline.

Parameters:
- DEPTH, 4, maximum number of unresolved branches in flight (power of two, 2..16).
- PC_TRITS, 8, width of the PC in trits. The PC is opaque here and never used in arithmetic.
- FLUSH_CYCLES, 2, number of cycles dec_ready stays low after a mispredict (>=1).
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- dec_valid  in  1  decode stage holds a valid instruction.
- dec_is_branch  in  1  the decode instruction is a conditional branch.
- dec_predict_taken  in  1  prediction issued for that branch.
- dec_alt_pc  in  trit_t[PC_TRITS-1:0]  PC of the path not chosen: target if predicted not-taken, fall-through if predicted taken.
- dec_ready  out  1  resolver can accept a branch this cycle.
- ex_valid  in  1  execute resolves the oldest outstanding branch this cycle.
- ex_taken  in  1  actual outcome of that branch.
- flush_o  out  1  one-cycle pulse: kill all younger instructions.
- redirect_pc_o  out  trit_t[PC_TRITS-1:0]  fetch target; valid while flush_o=1.
- stat_branches_o  out  CNT_W  number of resolved branches.
- stat_mispredicts_o  out  CNT_W  number of mispredicted branches.
- err_o  out  1  sticky flag: ex_valid seen with queue empty.

Behaviour:
- Reset (async, rst_n=0):
  - queue empty (count=0, rd/wr pointers 0), state=RUN, flush counter 0.
  - flush_o=0, redirect_pc_o = all T_ZERO, both statistics counters 0, err_o=0.
  - dec_ready=1 in the first cycle after reset release.
  - Reset mid-flush aborts the flush immediately.
- Queue: in-order FIFO of entries {pred, alt_pc}, DEPTH entries.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
- Push when dec_valid && dec_is_branch && dec_ready.
- dec_ready = (state==RUN) && (count<DEPTH). It is registered-state only, with no combinational path from ex_*. When full it stays low even if a pop happens in the same cycle.
- Pop when ex_valid && count!=0, at the head only.
  - An entry pushed in cycle N is not resolvable before cycle N+1.
  - Simultaneous push and correct-prediction pop: count is unchanged and both pointers advance.
- ex_valid with count==0: err_o is set (sticky until reset). No statistics change and no flush.
- Correct prediction (ex_taken==head.pred): stat_branches increments.
- Mispredict (ex_taken!=head.pred) in cycle N:
  - stat_branches and stat_mispredicts both increment.
  - Entire queue cleared (younger entries are wrong-path). A same-cycle push is discarded.
  - Cycle N+1: flush_o=1, redirect_pc_o=head.alt_pc captured at N, state=FLUSH.
- Both statistics counters saturate at 2^CNT_W-1 and never wrap.
- FSM states: RUN, FLUSH.
  - RUN -> FLUSH on mispredict. The flush counter loads FLUSH_CYCLES-1.
  - FLUSH: flush_o is high only in the first FLUSH cycle. dec_ready=0, pushes are ignored, and ex_valid is ignored (the queue is empty, so err_o is not set).
  - FLUSH decrements the counter each cycle and returns FLUSH -> RUN in the cycle after the counter reads 0.
  - FLUSH_CYCLES=2 gives exactly 2 cycles of dec_ready=0 starting at N+1.
- redirect_pc_o holds its last value outside flush_o cycles.

Decomposition:
- ternary_pkg gains:
  - brq_entry_t: packed struct {logic pred; trit_t [PC_TRITS-1:0] alt_pc}, using a package localparam BR_PC_TRITS=8 as the default.
  - brr_state_t: enum {BRR_RUN, BRR_FLUSH}.
- One sub-module: ternary_brq_fifo.
  - Parameterised DEPTH and entry type.
  - Provides push, pop, clear, head output, full, empty and count.
  - clear has priority over push.
- FSM, flush counter, comparison and statistics stay in the top module.

Test Plan:
1. Reset, then push 3 branches with pred=1, alt_pc values A, B, C; resolve them taken, one per cycle -> stat_branches=3, stat_mispredicts=0, flush_o never high, queue empty.
2. Push pred=0 with alt_pc=T, plus a younger branch; resolve the first with ex_taken=1 at cycle N -> flush_o=1 only at N+1, redirect_pc_o=T, dec_ready=0 at N+1..N+2, count=0, stat_mispredicts=1; the younger branch never resolves.
3. Fill 4 entries -> dec_ready=0. Push plus correct pop in the same cycle while count=3 -> count stays 3; a push attempt while full is dropped.
4. ex_valid with the queue empty -> err_o=1 and stays 1 through later traffic; counters unchanged.
5. CNT_W=4: resolve 20 mispredicts -> both counters hold at 15.
6. Assert rst_n=0 during FLUSH -> all outputs return to reset values asynchronously, and dec_ready=1 in the first cycle after release.
